// File: rtl/core_pkg.sv
// Shared core definitions: NOP encoding, major opcodes, ALU operation
// selectors and the fetch-queue entry type used between IF and ID.
package core_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LW     = 7'b000_0011;
    localparam logic [6:0] OPC_SW     = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } ifq_entry_t;

endpackage

// File: rtl/if_queue.sv
// Synchronous instruction FIFO between fetch and decode. Flush wins over
// push/pop; a push is accepted when full only if a pop frees the slot in the
// same cycle. DEPTH must be a power of two.
module if_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  ifq_entry_t               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output ifq_entry_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    ifq_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage. Issues sequential word fetches under a credit
// rule (queued + in-flight < QDEPTH), tags in-order responses with their PC,
// queues them for ID and handles redirects by flushing the queue and
// discarding responses to requests issued before the redirect.
// Optional macro IF_STAGE_PERF_CNT_EN adds the fetch_count port/counter.
module if_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_ir,
    output logic [31:0] id_pc
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop_cnt_nxt;
    logic [CW-1:0] q_count;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_live;
    logic          rsp_drop;
    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    ifq_entry_t    q_in;
    ifq_entry_t    q_head;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Stale (to-be-dropped) requests still occupy credit until they return.
    assign credit_used    = (CW+1)'(q_count) + (CW+1)'(outstanding) + (CW+1)'(drop_cnt);
    assign imem_req_valid = !reset && (credit_used < (CW+1)'(QDEPTH));
    assign imem_req_addr  = {fetch_pc[31:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_live = imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);

    // Live requests are consecutive words ending just below fetch_pc, so the
    // oldest one sits outstanding words back.
    assign q_in.ir = imem_rsp_data;
    assign q_in.pc = fetch_pc - (32'(outstanding) << 2);
    assign q_push  = rsp_live && !redirect_valid;
    assign q_pop   = id_ready && !redirect_valid;

    if_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign id_valid = !q_empty;
    assign id_ir    = q_empty ? NOP   : q_head.ir;
    assign id_pc    = q_empty ? 32'h0 : q_head.pc;

    // On redirect everything still in flight (including this cycle's new
    // request, minus this cycle's response) becomes stale.
    always_comb begin
        outstanding_nxt = outstanding;
        drop_cnt_nxt    = drop_cnt;
        if (redirect_valid) begin
            drop_cnt_nxt    = drop_cnt + outstanding + CW'(req_fire)
                              - CW'(rsp_live || rsp_drop);
            outstanding_nxt = '0;
        end else begin
            outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_live);
            drop_cnt_nxt    = drop_cnt - CW'(rsp_drop);
        end
    end

    // Fetch PC and in-flight counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
            if (redirect_valid)
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    // Counts instructions actually delivered to the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_count <= '0;
        else if (q_push)
            fetch_count <= fetch_count + 32'd1;
    end
`endif

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (outstanding == '0) && (drop_cnt == '0)));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model (list of in-flight
// requests with stale flags, and a list of queued instructions).
module tb_if_stage;
    import core_pkg::*;

    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_pc;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    if_stage #(
        .RESET_PC (RPC),
        .QDEPTH   (QD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_pc          (id_pc)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    req_t        infl[$];
    ifq_entry_t  idq[$];
    logic [31:0] m_pc;
    logic [31:0] m_count;
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;
    int          vectors;
    int          miscompares;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check_outputs();
        logic exp_rv;
        exp_rv = (idq.size() + infl.size()) < QD;
        check_val("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check_val("req_addr", imem_req_addr, m_pc);
        if (idq.size() > 0) begin
            check_val("id_valid", 32'(id_valid), 32'd1);
            check_val("id_ir", id_ir, idq[0].ir);
            check_val("id_pc", id_pc, idq[0].pc);
        end else begin
            check_val("id_valid", 32'(id_valid), 32'd0);
            check_val("id_ir", id_ir, NOP);
            check_val("id_pc", id_pc, 32'h0);
        end
`ifdef IF_STAGE_PERF_CNT_EN
        check_val("fetch_count", fetch_count, m_count);
`endif
    endtask

    // One clock: check, drive, advance the model at the edge.
    task automatic step(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc);
        int          e;
        int          d;
        bit          rsp;
        bit          fire;
        req_t        r;
        #1;
        check_outputs();
        e   = cyc + 1;
        rsp = (infl.size() > 0) && (infl[0].due <= e);
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(infl[0].addr) : $urandom();
        fire = ((idq.size() + infl.size()) < QD) && rdy;
        @(posedge clk);
        cyc = e;
        if (idr && !redir && idq.size() > 0) void'(idq.pop_front());
        if (rsp) begin
            r = infl.pop_front();
            if (!r.stale && !redir) begin
                idq.push_back(ifq_entry_t'{ir: mem_word(r.addr), pc: r.addr});
                m_count++;
            end
        end
        if (fire) begin
            d = e + $urandom_range(lat_max, lat_min);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            infl.push_back('{addr: m_pc, stale: 1'b0, due: d});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            foreach (infl[i]) infl[i].stale = 1'b1;
            idq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (infl.size() + idq.size()) != 0; i++)
            step(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    // Asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        reset          = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("rst_id_valid", 32'(id_valid), 32'd0);
        check_val("rst_id_ir", id_ir, NOP);
        check_val("rst_id_pc", id_pc, 32'h0);
`ifdef IF_STAGE_PERF_CNT_EN
        check_val("rst_fetch_count", fetch_count, 32'h0);
`endif
        infl.delete();
        idq.delete();
        m_pc    = RPC;
        m_count = '0;
        @(posedge clk);
        cyc      = cyc + 1;
        last_due = cyc;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        m_pc           = RPC;
        m_count        = '0;
        cyc            = 0;
        last_due       = 0;
        lat_min        = 1;
        lat_max        = 1;

        repeat (3) @(negedge clk);
        do_reset();

        // Streaming with a 1-cycle memory: 0,4,8,12 issued and consumed.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Decode stalled: credit stops issue after QD requests.
        drain();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        #1 check_val("credit_stall", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect with two requests outstanding; both responses dropped.
        drain();
        lat_min = 3;
        lat_max = 3;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        #1 check_val("redir_addr", imem_req_addr, 32'h0000_0100);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect on a full queue while popping: empty on the next cycle.
        drain();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        #1 check_val("flush_id_valid", 32'(id_valid), 32'd0);
        check_val("flush_id_ir", id_ir, NOP);

        // Address wrap at the top of the address space.
        drain();
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        #1 check_val("pc_wrap", imem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Random traffic with variable memory latency and redirects.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            rpc = $urandom();
            if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            step(($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 6),
                 ($urandom_range(99, 0) < 4), rpc);
        end

        // Reset mid-stream with three instructions queued.
        drain();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 20 && idq.size() < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("pre_rst_id_valid", 32'(id_valid), 32'd1);
        do_reset();
        #1 check_val("post_rst_addr", imem_req_addr, RPC);
        check_val("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 4, meaning instruction-queue entries; legal values are powers of 2 from 2 to 16.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  returned instruction valid; responses in request order, at most one per cycle.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect from EX.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 id_valid  output  1  id_ir/id_pc hold a real instruction for ID.
REQ-013 id_ready  input  1  ID consumes the head entry this cycle.
REQ-014 id_ir  output  32  instruction to ID (the IFID_IR source).
REQ-015 id_pc  output  32  PC of id_ir.
REQ-016 fetch_count  output  32  present only when IF_STAGE_PERF_CNT_EN is defined.

Function
REQ-017 fetch_pc SHALL hold the next request address; imem_req_addr SHALL equal fetch_pc with bits [1:0] forced to 0.
REQ-018 imem_req_valid SHALL be 1 iff (queue occupancy + outstanding) < QDEPTH, with outstanding = requests accepted but not yet responded; this credit rule guarantees the queue never overflows.
REQ-019 On imem_req_valid && imem_req_ready, fetch_pc SHALL increment by 4 (mod 2^32, wrapping 0xFFFF_FFFC to 0) and outstanding SHALL increment.
REQ-020 On imem_rsp_valid with drop_cnt == 0, {imem_rsp_data, rsp_pc} SHALL be pushed to the queue, where rsp_pc is the address of the oldest outstanding request.
REQ-021 Latency: id_valid SHALL rise in the cycle after the pushing response; there is no combinational path from imem_rsp_* to id_*.
REQ-022 id_valid SHALL equal queue non-empty; id_ir and id_pc SHALL show the head entry; when the queue is empty, id_ir SHALL be 32'h0000_0013 (NOP) and id_pc SHALL be 0.
REQ-023 On id_valid && id_ready, the head entry SHALL be popped; id_ready while empty SHALL have no effect.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged, including when the queue is full.
REQ-025 On redirect_valid, in the same edge, the queue SHALL be flushed, fetch_pc SHALL be set to {redirect_pc[31:2], 2'b00}, and drop_cnt SHALL be set to the number of outstanding requests not answered that cycle, counting a request accepted that same cycle.
REQ-026 redirect SHALL take priority over same-cycle push and pop; responses arriving while drop_cnt > 0 SHALL be discarded, and each one SHALL decrement drop_cnt.
REQ-027 While drop_cnt > 0, the credit rule in REQ-018 SHALL count drop_cnt as outstanding.
REQ-028 A response with outstanding == 0 and drop_cnt == 0 SHALL be ignored and SHALL trigger a simulation-only assertion.

Reset
REQ-029 While reset is high: fetch_pc = RESET_PC, queue empty, outstanding = 0, drop_cnt = 0, id_valid = 0, id_ir = NOP, id_pc = 0, fetch_count = 0.
REQ-030 imem_req_valid SHALL be 0 during reset and SHALL assert in the first cycle after deassertion.
REQ-031 Reset asserted mid-operation SHALL abandon all in-flight responses; responses arriving after deassertion for pre-reset requests are a system-level error and out of scope.

Configuration
REQ-032 With IF_STAGE_PERF_CNT_EN defined, fetch_count SHALL increment (wrapping) on each queue push, i.e. not on discarded responses; without the macro, neither the port nor the counter exists.

Structure
REQ-033 NOP (32'h0000_0013), the opcode constants LW/SW/BRANCH/ALUOp, and the queue entry typedef {ir, pc} SHALL live in shared package core_pkg.
REQ-034 The queue SHALL be a separate sub-module if_queue (synchronous FIFO, parameter DEPTH, with push/pop/flush/full/empty).

Verification
REQ-035 Reset release, RESET_PC = 0, ready = 1, 1-cycle memory -> addrs 0, 4, 8, 12 issued; id_pc = 0, 4, 8 in successive cycles with id_ready = 1.
REQ-036 id_ready = 0 with QDEPTH = 4 -> exactly 4 requests issued, then imem_req_valid = 0 until a pop.
REQ-037 Redirect to 0x103 with 2 requests outstanding -> next addr 0x100; the 2 stale responses are dropped; first id_pc = 0x100.
REQ-038 Redirect in the same cycle as push and pop on a full queue -> queue empty the next cycle, id_ir = 0x0000_0013.
REQ-039 fetch_pc = 0xFFFF_FFFC accepted -> next addr 0x0000_0000.
REQ-040 Reset asserted mid-stream with 3 entries queued -> id_valid = 0 immediately; first post-reset addr = RESET_PC; fetch_count = 0 (macro on).
